ram_n_clear: RTL and testbench

Parametrised successor to the fixed-size Hack RAM chips: a WIDTH x 2**ADDR_W single-port RAM with the same load/address/out behaviour, plus a background clear engine. After reset, and on request, the engine wipes every word to zero, one word per clock. It reports progress on `busy` and flags any write it rejects. It sits wherever the CPU/memory map previously instantiated RAM512-class chips and a known power-up state is needed.

---
 rtl/ram_pkg.sv | 20 ++
 rtl/ram_clear_seq.sv | 102 ++++++++++
 rtl/ram_n_clear.sv | 61 ++++++
 tb/tb_ram_n_clear.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_pkg
// Purpose  : Shared types and constants for the ram_n_clear RAM and its
//            background clear sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package ram_pkg;

  // Clear engine states: IDLE serves loads, CLEAR wipes one word per clock.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Value written into every word by the wipe, also shown on out while busy.
  localparam int CLEAR_VALUE = 0;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_clear_seq.sv
`default_nettype none
// ============================================================================
// Module   : ram_clear_seq
// Purpose  : Clear engine for ram_n_clear. Holds the IDLE/CLEAR state, the
//            wipe pointer and the rejected-load flag, and steers the single
//            memory write port between the user load and the wipe.
// Revision : 1.0 - initial release
// ============================================================================
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [WIDTH-1:0]  i_in,
  output logic              o_busy,
  output logic              o_load_dropped,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [WIDTH-1:0]  o_wdata
);

  // Last word of the array; all-ones equals DEPTH-1 for DEPTH = 2**ADDR_W.
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = '1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   w_ptr_nxt;
  logic                r_load_dropped;
  logic                w_load_dropped_nxt;

  // State, pointer and drop-flag registers; reset starts a fresh wipe.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= CLEAR;
      r_ptr          <= '0;
      r_load_dropped <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_ptr          <= w_ptr_nxt;
      r_load_dropped <= w_load_dropped_nxt;
    end
  end

  // Next-state, pointer advance and write-port steering.
  always_comb begin
    w_state_nxt        = r_state;
    w_ptr_nxt          = r_ptr;
    // A load is lost whenever the engine is wiping or a clear arrives with it.
    w_load_dropped_nxt = i_load && ((r_state == CLEAR) || i_clear);
    o_we               = 1'b0;
    o_waddr            = i_address;
    o_wdata            = i_in;

    case (r_state)
      IDLE: begin
        if (i_clear) begin
          w_state_nxt = CLEAR;
          w_ptr_nxt   = '0;
        end else if (i_load) begin
          o_we = 1'b1;
        end
      end

      CLEAR: begin
        o_we    = 1'b1;
        o_waddr = r_ptr;
        o_wdata = WIDTH'(CLEAR_VALUE);
        if (i_clear) begin
          // Restart: the full DEPTH-cycle wipe begins again from word 0.
          w_ptr_nxt = '0;
        end else if (r_ptr == c_LAST_ADDR) begin
          // Pointer is held rather than wrapped so the engine parks cleanly.
          w_state_nxt = IDLE;
        end else begin
          w_ptr_nxt = r_ptr + ADDR_W'(1);
        end
      end

      default: begin
        w_state_nxt = CLEAR;
        w_ptr_nxt   = '0;
      end
    endcase

    // Nothing reaches the array while reset is held.
    if (reset) begin
      o_we = 1'b0;
    end
  end

  assign o_busy         = (r_state == CLEAR);
  assign o_load_dropped = r_load_dropped;

endmodule : ram_clear_seq
`default_nettype wire

// File: rtl/ram_n_clear.sv
`default_nettype none
// ============================================================================
// Module   : ram_n_clear
// Purpose  : WIDTH x 2**ADDR_W single-port RAM with Hack-style load/address/
//            out behaviour and a background engine that zeroes every word
//            after reset or on request, one word per clock.
// Revision : 1.0 - initial release
// ============================================================================
module ram_n_clear
  import ram_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy,
  output logic              load_dropped
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [WIDTH-1:0]  w_wdata;

  ram_clear_seq #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_seq (
    .clock          (clock),
    .reset          (reset),
    .i_clear        (clear),
    .i_load         (load),
    .i_address      (address),
    .i_in           (in),
    .o_busy         (busy),
    .o_load_dropped (load_dropped),
    .o_we           (w_we),
    .o_waddr        (w_waddr),
    .o_wdata        (w_wdata)
  );

  // Single write port, shared by user loads and the wipe.
  always_ff @(posedge clock) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Zero-latency read; masked mid-wipe so no stale words leak out.
  assign out = busy ? WIDTH'(CLEAR_VALUE) : r_mem[address];

endmodule : ram_n_clear
`default_nettype wire

// File: tb/tb_ram_n_clear.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_n_clear
// Purpose  : Self-checking bench for ram_n_clear (default size plus an
//            8 x 8 variant) against a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_n_clear;

  localparam int DEPTH = 512;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in = '0;
  logic        load = 1'b0;
  logic [8:0]  address = '0;
  logic        clear = 1'b0;
  logic [15:0] out;
  logic        busy;
  logic        load_dropped;

  logic        s_reset = 1'b0;
  logic [7:0]  s_in = '0;
  logic        s_load = 1'b0;
  logic [2:0]  s_address = '0;
  logic        s_clear = 1'b0;
  logic [7:0]  s_out;
  logic        s_busy;
  logic        s_load_dropped;

  ram_n_clear #(.WIDTH(16), .ADDR_W(9)) dut (
    .clock(clock), .reset(reset), .in(in), .load(load), .address(address),
    .clear(clear), .out(out), .busy(busy), .load_dropped(load_dropped)
  );

  ram_n_clear #(.WIDTH(8), .ADDR_W(3)) dut_s (
    .clock(clock), .reset(s_reset), .in(s_in), .load(s_load), .address(s_address),
    .clear(s_clear), .out(s_out), .busy(s_busy), .load_dropped(s_load_dropped)
  );

  always #5 clock = ~clock;

  // Reference model: word array, cycles of wipe remaining, last drop flag.
  logic [15:0] m_mem [DEPTH];
  int          m_rem = 0;
  logic        m_drop = 1'b0;
  bit          m_ok = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] m_read(input logic [8:0] a);
    return (m_rem > 0) ? 16'h0000 : m_mem[a];
  endfunction

  task automatic m_wipe();
    foreach (m_mem[i]) m_mem[i] = 16'h0000;
    m_rem = DEPTH;
  endtask

  // One clock: drive, check the pre-edge read, clock, update model, check.
  task automatic step(input bit r, input bit c, input bit l,
                      input logic [8:0] a, input logic [15:0] d);
    reset = r; clear = c; load = l; address = a; in = d;
    #1;
    if (m_ok) check("out_pre_edge", {16'h0, out}, {16'h0, m_read(a)});
    @(posedge clock);
    if (r) begin
      m_wipe();
      m_drop = 1'b0;
      m_ok   = 1'b1;
    end else begin
      m_drop = l && ((m_rem > 0) || c);
      if (c)            m_wipe();
      else if (m_rem > 0) m_rem--;
      else if (l)       m_mem[a] = d;
    end
    #1;
    if (m_ok) begin
      check("busy", {31'h0, busy}, {31'h0, (m_rem > 0)});
      check("load_dropped", {31'h0, load_dropped}, {31'h0, m_drop});
      check("out_post_edge", {16'h0, out}, {16'h0, m_read(a)});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 9'($urandom_range(0, 511)), 16'h0);
  endtask

  // Counts busy cycles from the event step just taken; bounded at 600 steps.
  task automatic wipe_len(input string tag);
    int cnt;
    cnt = busy ? 1 : 0;
    for (int i = 0; i < 600; i++) begin
      step(1'b0, 1'b0, 1'b0, 9'($urandom_range(0, 511)), 16'h0);
      if (busy) cnt++;
    end
    check(tag, cnt, 512);
  endtask

  task automatic sweep();
    for (int a = 0; a < DEPTH; a += 16) step(1'b0, 1'b0, 1'b0, 9'(a), 16'h0);
  endtask

  initial begin
    int cnt;

    // Reset wipe.
    step(1'b1, 1'b0, 1'b0, 9'd0, 16'h0);
    check("reset_busy", {31'h0, busy}, 32'd1);
    check("reset_out", {16'h0, out}, 32'd0);
    check("reset_drop", {31'h0, load_dropped}, 32'd0);
    wipe_len("reset_wipe_len");
    sweep();

    // Single write at 128.
    step(1'b0, 1'b0, 1'b1, 9'd128, 16'd15);
    check("write_128", {16'h0, out}, 32'd15);
    sweep();

    // Clear beats load, then a load during the wipe.
    step(1'b0, 1'b1, 1'b1, 9'd3, 16'd9);
    check("clear_beats_load_drop", {31'h0, load_dropped}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 9'd5, 16'd7);
    check("busy_write_drop", {31'h0, load_dropped}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 9'd5, 16'd0);
    check("busy_write_drop_ends", {31'h0, load_dropped}, 32'd0);
    cnt = 3;
    for (int i = 0; i < 600 && busy; i++) begin
      step(1'b0, 1'b0, 1'b0, 9'($urandom_range(0, 511)), 16'h0);
      if (busy) cnt++;
    end
    check("clear_wipe_len", cnt, 512);
    step(1'b0, 1'b0, 1'b0, 9'd3, 16'h0);
    check("after_clear_3", {16'h0, out}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 9'd5, 16'h0);
    check("after_clear_5", {16'h0, out}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 9'd128, 16'h0);
    check("after_clear_128", {16'h0, out}, 32'd0);

    // Restart mid-wipe: reset at wipe cycle 200, clear at wipe cycle 300.
    step(1'b0, 1'b0, 1'b1, 9'd77, 16'hBEEF);
    step(1'b1, 1'b0, 1'b0, 9'd0, 16'h0);
    idle(199);
    step(1'b1, 1'b0, 1'b0, 9'd0, 16'h0);
    wipe_len("reset_restart_len");
    step(1'b0, 1'b0, 1'b1, 9'd300, 16'h1234);
    step(1'b0, 1'b1, 1'b0, 9'd0, 16'h0);
    idle(299);
    step(1'b0, 1'b1, 1'b0, 9'd0, 16'h0);
    wipe_len("clear_restart_len");
    sweep();
    step(1'b0, 1'b0, 1'b0, 9'd300, 16'h0);
    check("restart_300_zero", {16'h0, out}, 32'd0);

    // Randomised traffic, concentrated on a few addresses so words are reread.
    for (int i = 0; i < 2500; i++) begin
      step($urandom_range(0, 999) == 0, $urandom_range(0, 399) == 0,
           $urandom_range(0, 2) != 0,
           ($urandom_range(0, 7) == 0) ? 9'd511 : 9'($urandom_range(0, 31)),
           16'($urandom));
    end
    idle(DEPTH + 2);
    for (int a = 0; a < 32; a++) step(1'b0, 1'b0, 1'b0, 9'(a), 16'h0);

    // Parameter variant: 8 words of 8 bits.
    s_reset = 1'b1;
    @(posedge clock); #1;
    s_reset = 1'b0;
    s_address = 3'd7;
    cnt = s_busy ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (s_busy) cnt++;
    end
    check("small_wipe_len", cnt, 8);
    check("small_out7_zero", {24'h0, s_out}, 32'd0);
    s_load = 1'b1; s_in = 8'hA5;
    #1;
    check("small_out7_pre", {24'h0, s_out}, 32'd0);
    @(posedge clock); #1;
    s_load = 1'b0;
    check("small_out7", {24'h0, s_out}, 32'hA5);
    check("small_drop", {31'h0, s_load_dropped}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (s_busy || s_out !== 8'hA5) cnt++;
    end
    check("small_no_wrap", cnt, 0);
    s_address = 3'd0;
    #1;
    check("small_out0", {24'h0, s_out}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_ram_n_clear
`default_nettype wire
